// File: rtl/ap_hs_driver.sv
`default_nettype none
// ap_hs_driver: ap_ctrl_hs initiator that issues batched ap_start runs and queues each ap_return in a result FIFO.
// Define AP_HS_DRIVER_TIMEOUT_EN to build the per-run timeout (sets err and aborts the batch).
module ap_hs_driver #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              cmd_start,
  input  logic [7:0]        cmd_runs,
  output logic              busy,
  output logic              batch_done,
  output logic              err,
  output logic              core_start,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic              core_idle,
  input  logic [DATA_W-1:0] core_return,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        runs_left;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_en;
  logic              pop;
  logic              last_run;
  logic              fifo_full;
  logic              tmo;

  assign wr_en     = ((state == ISSUE) && core_ready && core_done) || ((state == WAIT) && core_done);
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem[rd_ptr];
  assign last_run  = (runs_left == 8'd1);
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));

`ifdef AP_HS_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  assign tmo = (((state == ISSUE) && !core_ready) || ((state == WAIT) && !core_done))
               && (tcnt == TW'(TIMEOUT - 1));
  assign err = err_q;

  // Counter restarts whenever ISSUE or WAIT is (re)entered.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_start)
        err_q <= 1'b0;
      else if (tmo)
        err_q <= 1'b1;
      if (((state != ISSUE) && (state != WAIT)) || ((state == ISSUE) && core_ready) || tmo)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      runs_left  <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      core_start <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            runs_left <= cmd_runs;
            if (cmd_runs == 8'd0) begin
              batch_done <= 1'b1;
            end else begin
              state <= GAP;
              busy  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (core_idle && !fifo_full) begin
            state      <= ISSUE;
            core_start <= 1'b1;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            core_start <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: ;
        default: state <= IDLE;
      endcase

      // Run completion overrides the ISSUE->WAIT move when ready and done coincide.
      if (wr_en) begin
        runs_left  <= runs_left - 8'd1;
        core_start <= 1'b0;
        if (last_run) begin
          state      <= IDLE;
          busy       <= 1'b0;
          batch_done <= 1'b1;
        end else begin
          state <= GAP;
        end
      end else if (tmo) begin
        runs_left  <= '0;
        core_start <= 1'b0;
        state      <= IDLE;
        busy       <= 1'b0;
        batch_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= core_return;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ap_hs_driver.sv
`default_nettype none
// Self-checking bench for ap_hs_driver: table of batch vectors against a reactive ap_ctrl_hs core model.
module tb_ap_hs_driver;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [7:0]  cmd_runs = '0;
  logic        busy, batch_done, err, core_start, res_valid;
  logic        core_ready, core_done, core_idle;
  logic [31:0] core_return, res_data;
  logic        res_ready = 1'b0;

  logic        m_ready = 1'b0, m_done = 1'b0, m_idle = 1'b1;
  logic [31:0] m_ret = '0;
  logic        x_ready = 1'b0, x_done = 1'b0;

  assign core_ready  = m_ready | x_ready;
  assign core_done   = m_done | x_done;
  assign core_idle   = m_idle;
  assign core_return = m_ret;

  ap_hs_driver #(.DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_start(cmd_start), .cmd_runs(cmd_runs),
    .busy(busy), .batch_done(batch_done), .err(err), .core_start(core_start),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_return(core_return), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 ap_clk = ~ap_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge ap_clk);
  endtask

  // Core model controls (owned by the stimulus process)
  int          rdy = 1, dn = 1, gen = 0;
  logic [31:0] first_ret = '0;
  int          done_base = 0;
  // Core model state (owned by the model process)
  int          last_gen = 0, cnt = 0, n_starts = 0, n_done = 0;
  bit          active = 1'b0;

  always @(negedge ap_clk) begin
    m_ready = 1'b0;
    m_done  = 1'b0;
    if (ap_rst || gen != last_gen) begin
      active   = 1'b0;
      m_idle   = 1'b1;
      last_gen = gen;
    end else begin
      if (!active && core_start) begin
        active   = 1'b1;
        cnt      = 0;
        m_idle   = 1'b0;
        n_starts = n_starts + 1;
      end
      if (active) begin
        if (cnt == rdy - 1) m_ready = 1'b1;
        if (dn != 0 && cnt == dn - 1) begin
          m_done = 1'b1;
          m_ret  = first_ret + 32'(n_done - done_base);
          n_done = n_done + 1;
          active = 1'b0;
          m_idle = 1'b1;
        end
        cnt = cnt + 1;
      end
    end
  end

  // Output monitor: results must emerge in issue order
  logic [31:0] exp_base = '0;
  int          pop_base = 0, pop_idx = 0, bd_count = 0;

  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (batch_done) bd_count = bd_count + 1;
      if (res_valid && res_ready) begin
        chk("res_data", 64'(res_data), 64'(exp_base + 32'(pop_idx - pop_base)));
        pop_idx = pop_idx + 1;
      end
    end
  end

  typedef struct {
    logic [7:0]  runs;
    int          rdy;
    int          dn;
    logic [31:0] first;
    int          exp_starts;
  } vec_t;

  vec_t tbl[5];
  int   sb, bb;
  bit   found, saw_valid;

  task automatic setup_batch(input int r, input int d, input logic [31:0] f);
    rdy = r; dn = d; first_ret = f; gen = gen + 1;
    tick;
    done_base = n_done; exp_base = f; pop_base = pop_idx;
    sb = n_starts; bb = bd_count;
  endtask

  task automatic wait_batch_done(input string name);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick;
      if (batch_done) begin found = 1'b1; break; end
    end
    chk(name, 64'(found), 64'd1);
  endtask

  initial begin
    tbl[0] = '{runs: 8'd1, rdy: 2, dn: 5, first: 32'h0000_0007, exp_starts: 1};
    tbl[1] = '{runs: 8'd3, rdy: 1, dn: 3, first: 32'h0000_0100, exp_starts: 3};
    tbl[2] = '{runs: 8'd0, rdy: 1, dn: 1, first: 32'h0000_0000, exp_starts: 0};
    tbl[3] = '{runs: 8'd2, rdy: 1, dn: 1, first: 32'h0000_0055, exp_starts: 2};
    tbl[4] = '{runs: 8'd5, rdy: 3, dn: 4, first: 32'h0000_00a0, exp_starts: 5};

    // Reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      cmd_start = 1'($urandom); cmd_runs = 8'($urandom);
      x_ready = 1'($urandom); x_done = 1'($urandom); res_ready = 1'($urandom);
      tick;
      chk("reset_outputs", {59'd0, busy, batch_done, err, core_start, res_valid}, 64'd0);
      chk("reset_res_data", 64'(res_data), 64'd0);
    end
    cmd_start = 1'b0; x_ready = 1'b0; x_done = 1'b0; res_ready = 1'b1;
    ap_rst = 1'b0;
    tick;

    // Table-driven batches with a free-flowing result port
    for (int v = 0; v < 5; v++) begin
      setup_batch(tbl[v].rdy, tbl[v].dn, tbl[v].first);
      cmd_runs = tbl[v].runs; cmd_start = 1'b1;
      tick;
      cmd_start = 1'b0;
      chk("busy_after_cmd", 64'(busy), 64'(tbl[v].runs != 0));
      if (tbl[v].runs == 0)
        chk("zero_run_done", 64'(batch_done), 64'd1);
      else
        wait_batch_done("batch_done_seen");
      chk("busy_at_done", 64'(busy), 64'd0);
      repeat (8) tick;
      chk("starts", 64'(n_starts - sb), 64'(tbl[v].exp_starts));
      chk("results", 64'(pop_idx - pop_base), 64'(tbl[v].runs));
      chk("done_pulses", 64'(bd_count - bb), 64'd1);
      chk("err_clear", 64'(err), 64'd0);
    end

    // FIFO backpressure: only four runs fit before the result port drains
    res_ready = 1'b0;
    setup_batch(1, 2, 32'h0000_0200);
    cmd_runs = 8'd6; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    repeat (100) tick;
    chk("bp_starts", 64'(n_starts - sb), 64'd4);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_head", 64'(res_data), 64'h200);
    res_ready = 1'b1;
    wait_batch_done("bp_batch_done");
    repeat (8) tick;
    chk("bp_all_starts", 64'(n_starts - sb), 64'd6);
    chk("bp_all_results", 64'(pop_idx - pop_base), 64'd6);
    chk("bp_done_pulses", 64'(bd_count - bb), 64'd1);

    // Reset mid-run: once in WAIT (fast ready), once in ISSUE (slow ready)
    for (int k = 0; k < 2; k++) begin
      setup_batch((k == 0) ? 1 : 20, 30, 32'h0000_0300);
      cmd_runs = 8'd3; cmd_start = 1'b1;
      tick;
      cmd_start = 1'b0;
      repeat (4) tick;
      chk("mid_core_start", 64'(core_start), 64'(k == 1));
      #2 ap_rst = 1'b1;
      #1 chk("mid_reset_clear", {59'd0, busy, batch_done, err, core_start, res_valid}, 64'd0);
      tick;
      ap_rst = 1'b0;
      sb = n_starts;
      x_done = 1'b1;
      tick;
      x_done = 1'b0;
      saw_valid = 1'b0;
      repeat (6) begin
        tick;
        if (res_valid || busy || core_start) saw_valid = 1'b1;
      end
      chk("stray_done_ignored", 64'(saw_valid), 64'd0);
      chk("no_start_after_reset", 64'(n_starts - sb), 64'd0);
    end

`ifdef AP_HS_DRIVER_TIMEOUT_EN
    // Core that never completes: abort 16 cycles after WAIT entry
    setup_batch(1, 0, 32'h0);
    cmd_runs = 8'd2; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ap_clk);
      if (core_ready) begin found = 1'b1; break; end
    end
    chk("tmo_ready_seen", 64'(found), 64'd1);
    repeat (15) @(posedge ap_clk);
    #1 chk("tmo_not_yet", {62'd0, err, batch_done}, 64'd0);
    @(posedge ap_clk);
    #1 chk("tmo_fire", {60'd0, err, batch_done, busy, core_start}, 64'b1100);
    setup_batch(1, 2, 32'h0000_0400);
    cmd_runs = 8'd1; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    chk("tmo_err_cleared", 64'(err), 64'd0);
    wait_batch_done("tmo_next_batch");
    repeat (4) tick;
    chk("tmo_next_result", 64'(pop_idx - pop_base), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ap_hs_driver.md
# ap_hs_driver

Initiator for the `ap_ctrl_hs` block-level handshake used by the HLS-generated cores (`top_add` and friends).
- Issues a programmed number of `ap_start` runs to one core.
- Captures each `ap_return` into a 4-entry result FIFO and streams the results out over valid/ready.
- Sits between the system controller and the core's wrapper, on the opposite side of the handshake from the core.

## Interface
Parameters:
- `DATA_W`, 32, width of the core's `ap_return` and of `res_data`.
- `FIFO_DEPTH`, 4, result FIFO entries; must be a power of two, 2..16.
- `TIMEOUT`, 1024, maximum cycles per run before an abort (used only with the macro enabled).

Ports:
- `ap_clk`  in  1  clock; all logic is on the rising edge.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `cmd_start`  in  1  one-cycle request to begin a batch.
- `cmd_runs`  in  8  number of runs in the batch; sampled when `cmd_start` is accepted.
- `busy`  out  1  high while a batch is in progress.
- `batch_done`  out  1  one-cycle pulse when the batch ends.
- `err`  out  1  sticky timeout flag.
- `core_start`  out  1  drives the core's `ap_start`.
- `core_ready`  in  1  from the core's `ap_ready`.
- `core_done`  in  1  from the core's `ap_done`.
- `core_idle`  in  1  from the core's `ap_idle`.
- `core_return`  in  DATA_W  from the core's `ap_return`.
- `res_valid`  out  1  result FIFO is non-empty.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  DATA_W  head-of-FIFO result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE
  - `cmd_start` loads `runs_left = cmd_runs` and clears `err`.
  - If `cmd_runs == 0`: `batch_done` pulses on the next cycle and the FSM stays in IDLE.
  - Otherwise the FSM goes to GAP.
- GAP
  - Moves to ISSUE when `core_idle == 1` and `fifo_count < FIFO_DEPTH`.
  - This space reservation guarantees that a `core_done` never finds the FIFO full.
- ISSUE
  - `core_start` is held at 1.
  - On `core_ready == 1`, the FSM goes to WAIT; `core_start` is 0 from the next cycle.
  - If `core_done` arrives in the same cycle as `core_ready`, the result is captured and the FSM treats the run as complete.
- WAIT
  - `core_start = 0`.
  - On `core_done == 1`, `core_return` is written to the FIFO and `runs_left` is decremented.
  - Then go to GAP if `runs_left` is still > 0; otherwise go to IDLE and pulse `batch_done`.
- `cmd_start` is ignored while `busy`.
- FIFO behaviour:
  - Simultaneous write and pop in the same cycle leaves the count unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - `res_data` is stable while `res_valid && !res_ready`.
- Any `core_done` seen in IDLE or GAP is ignored and does not change state.

## Timing
- Reset values: `core_start = 0`, `busy = 0`, `batch_done = 0`, `err = 0`, `res_valid = 0`, `res_data = 0`. FSM is in IDLE, FIFO is empty.
- Reset asserted mid-run clears everything immediately, including `core_start`.
- `busy` rises the cycle after `cmd_start` is accepted and falls in the same cycle that `batch_done` pulses.
- `core_start` rises the cycle after entry to GAP, at the earliest.
- A result is visible on `res_valid` the cycle after `core_done`.
- Minimum spacing between successive `core_start` rising edges is the core latency + 2 cycles.

## Configuration
- `AP_HS_DRIVER_TIMEOUT_EN` defined:
  - A cycle counter runs in ISSUE and WAIT and clears at each state entry.
  - When it reaches `TIMEOUT`: `err` is set, `core_start` drops, the remaining runs are discarded, the FSM goes to IDLE and `batch_done` pulses.
  - The FIFO contents are kept.
- Macro undefined:
  - No counter is built; `err` is tied to 0.
  - The FSM waits indefinitely for the core.

## Test plan
- Reset behaviour: drive `ap_rst = 1` with random inputs → all outputs are 0 and `core_start` never rises.
- Single run: `cmd_runs = 1`; core model asserts `core_ready` 2 cycles and `core_done` 5 cycles after start, with `core_return = 32'h0000_0007` → exactly one `core_start` window, `res_data = 7`, one `batch_done` pulse.
- FIFO backpressure: `cmd_runs = 6` with `res_ready = 0` → exactly 4 runs issue and the 5th is withheld. Raise `res_ready` → 6 results leave in order with no loss.
- Zero-run batch and fast core: `cmd_runs = 0` → `batch_done` next cycle with no `core_start`. Then `cmd_runs = 2` with `core_ready` and `core_done` in the same cycle → 2 results captured.
- Timeout (`AP_HS_DRIVER_TIMEOUT_EN`, `TIMEOUT = 16`): core never asserts `core_done` → `err = 1` and `batch_done` pulse 16 cycles after WAIT entry. A following `cmd_start` clears `err`.
- Reset mid-run: assert `ap_rst` during WAIT → all outputs clear immediately. A later `core_done` pulse is ignored and `res_valid` stays 0.
